// File: rtl/uart_receiver.sv
// 8N1 oversampling UART receiver with a one-entry valid/ready output buffer.
// Reports framing errors (stop bit low) and overruns (good byte dropped while buffer full).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | counting to mid start bit, rejects glitches
// S_DATA  | sampling 8 data bits, LSB first, one per bit time
// S_STOP  | sampling stop bit, delivers byte or flags framing error
// S_BREAK | line held low after framing error, waiting for rx_s high
module uart_receiver #(
  parameter int TICKS_PER_BAUD = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CW = $clog2(TICKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_TC = CW'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(TICKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            deliver;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    deliver = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_TC) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_TC) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop on the delivery edge frees the buffer for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (deliver) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: scoreboard of expected bytes popped on each valid/ready handshake,
// plus direct checks of latency, overrun, framing error, glitch rejection and reset.
module tb_uart_receiver;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  int n_checks = 0;
  int n_err    = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cnt = 0;
  int fe0, ov0, v0;
  logic [7:0] exp_q[$];
  logic [7:0] c3;

  always #5 clock = ~clock;

  uart_receiver #(.TICKS_PER_BAUD(T)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .data          (data),
    .valid         (valid),
    .ready         (ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (T) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (framing_error && overrun) both_cnt++;
      if (valid) valid_cnt++;
      if (valid && ready) begin
        chk("pop_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("pop_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    ready   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fe", 32'(framing_error), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(8);

    // single byte, exact latency
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    @(negedge clock);
    chk("t1_valid_pre", 32'(valid), 32'd0);
    @(negedge clock);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_data", 32'(data), 32'hA5);
    @(negedge clock);
    chk("t1_valid_post", 32'(valid), 32'd0);
    chk("t1_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_ov", 32'(ov_cnt - ov0), 32'd0);
    @(posedge clock); #1;
    idle(4);

    // back-to-back with ready low: overrun
    ov0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h00);
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clock);
    chk("t2_ov_pre", 32'(overrun), 32'd0);
    chk("t2_valid_pre", 32'(valid), 32'd1);
    @(negedge clock);
    chk("t2_ov", 32'(overrun), 32'd1);
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_data", 32'(data), 32'h00);
    @(negedge clock);
    chk("t2_ov_post", 32'(overrun), 32'd0);
    @(posedge clock); #1;
    ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t2_valid_popped", 32'(valid), 32'd0);
    chk("t2_data_held", 32'(data), 32'h00);
    chk("t2_ov_cnt", 32'(ov_cnt - ov0), 32'd1);
    @(posedge clock); #1;
    idle(4);

    // ready on the exact stop-sample cycle of the second frame
    ov0 = ov_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_byte(8'h12);
    send_byte(8'h34);
    ready = 1'b1;
    @(negedge clock);
    chk("t3_valid_old", 32'(valid), 32'd1);
    chk("t3_data_old", 32'(data), 32'h12);
    @(negedge clock);
    chk("t3_valid_new", 32'(valid), 32'd1);
    chk("t3_data_new", 32'(data), 32'h34);
    chk("t3_ov", 32'(overrun), 32'd0);
    @(negedge clock);
    chk("t3_valid_post", 32'(valid), 32'd0);
    chk("t3_ov_cnt", 32'(ov_cnt - ov0), 32'd0);
    @(posedge clock); #1;
    idle(4);

    // break: 12 bit times low
    fe0 = fe_cnt; v0 = valid_cnt;
    for (int i = 0; i < 12; i++) bit_time(1'b0);
    idle(3 * T);
    chk("t4_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    idle(2 * T);
    chk("t4_fe_after", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // one-cycle glitch
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cnt;
    rx = 1'b0;
    @(posedge clock); #1;
    idle(3 * T);
    chk("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("t5_no_ov", 32'(ov_cnt - ov0), 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81);
    idle(2 * T);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // reset during data bit 4 of 0xC3
    c3 = 8'hC3;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(c3[i]);
    rx = c3[4];
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    chk("t6_rst_data", 32'(data), 32'h00);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_fe", 32'(framing_error), 32'd0);
    chk("t6_rst_ov", 32'(overrun), 32'd0);
    @(posedge clock);
    @(posedge clock); #1;
    rx = 1'b1;
    reset_n = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cnt;
    idle(3 * T);
    chk("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
    ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    @(negedge clock);
    @(negedge clock);
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_data", 32'(data), 32'h5A);
    @(posedge clock); #1;
    ready = 1'b1;
    idle(4);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_no_ov", 32'(ov_cnt - ov0), 32'd0);
    chk("fe_ov_exclusive", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Oversampling UART receiver: deserialises the `uart_rx` serial line into bytes for the Wishbone master logic inside `top`.
- Sits directly behind the `uart_rx` pin, upstream of the UART-to-bus command decoder.
- Uses the same `TICKS_PER_BAUD` clocks-per-bit timing the cosimulator drives (4 in simulation).
- 8N1 framing, LSB first. One-entry output buffer with valid/ready handshake; framing-error and overrun reporting.

Parameters:
- `TICKS_PER_BAUD`, 4, clock cycles per bit. Even, >= 4. Tick counter width is `$clog2(TICKS_PER_BAUD)`.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  raw serial line; asynchronous to `clock`; idle high.
- `data`  out  8  received byte; meaningful while `valid` = 1.
- `valid`  out  1  buffer holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on any cycle where `valid` && `ready`.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because buffer full.

Behaviour:
- Reset (asynchronous, while `reset_n` = 0):
  - both synchroniser flops = 1; state IDLE; tick counter and bit index = 0; shift register = 0.
  - `data` = 0x00, `valid` = 0, `framing_error` = 0, `overrun` = 0.
  - Reset mid-frame abandons the frame with no pulse.
- Synchroniser: two flops. `rx_s` = second flop. The FSM uses only `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: `rx_s` == 0 -> START, counter = 0.
- START:
  - counter increments each cycle.
  - at counter == `TICKS_PER_BAUD`/2-1, sample `rx_s`.
  - `rx_s` == 1 -> IDLE (glitch, no pulse).
  - `rx_s` == 0 -> DATA, counter = 0, bit index = 0.
- DATA:
  - at counter == `TICKS_PER_BAUD`-1: shift `rx_s` into bit 7 of the shift register (right shift, LSB first), counter = 0, bit index +1.
  - after the 8th sample -> STOP.
- STOP: at counter == `TICKS_PER_BAUD`-1, sample `rx_s`.
  - `rx_s` == 1 -> deliver byte, -> IDLE.
  - `rx_s` == 0 -> `framing_error` pulses 1 cycle, byte discarded, -> BREAK.
- BREAK: stay until `rx_s` == 1, then -> IDLE. A held-low line never re-triggers START.
- Delivery, evaluated on the same edge as the stop sample:
  - buffer empty, or `valid` && `ready` this cycle -> `data` <= byte, `valid` <= 1, no overrun.
  - `valid` && !`ready` -> old `data` kept, `valid` stays 1, `overrun` pulses 1 cycle, new byte dropped.
- Pop: `valid` && `ready` with no delivery -> `valid` <= 0 next cycle; `data` holds its last value.
- `ready` while `valid` = 0 has no effect.
- Latency:
  - edge 0 = first rising edge capturing `rx` low in flop 1.
  - start sample at edge 2+`TICKS_PER_BAUD`/2; data bit k at edge 2+`TICKS_PER_BAUD`/2+(k+1)·`TICKS_PER_BAUD`; stop sample at edge 2+`TICKS_PER_BAUD`/2+9·`TICKS_PER_BAUD`.
  - `valid` is high after the stop-sample edge: edge 40 for `TICKS_PER_BAUD` = 4.
- Back-to-back frames: a start bit immediately following the stop bit is detected from IDLE with no dead time beyond the remaining half stop bit.
- `framing_error` and `overrun` are never high in the same cycle.

Test Plan:
- Byte 0xA5, `TICKS_PER_BAUD`=4, `ready`=1 -> `valid` high exactly 1 cycle after edge 40, `data`=0xA5, no error pulses.
- Frames 0x00 then 0xFF back-to-back, `ready`=0 throughout -> `data` stays 0x00, `valid`=1; `overrun` 1-cycle pulse at second stop sample; then `ready`=1 -> `valid` falls, 0xFF never appears.
- `ready` asserted on the exact cycle of the second stop sample (0x12 then 0x34) -> `data`=0x34, `valid` continuously 1, no overrun.
- `rx` low 12 bit-times (break), then high, then byte 0x3C -> one `framing_error` pulse, no `valid` during break, no second error; 0x3C then received correctly.
- `rx` low 1 cycle (glitch) -> FSM back to IDLE at start sample; no `valid`, no pulses; a subsequent 0x81 is received correctly.
- `reset_n` low for 2 cycles during data bit 4 of 0xC3, then full frame 0x5A -> all outputs 0 during reset, no pulse for the aborted frame, `data`=0x5A `valid`=1 after that frame.
